// File: rtl/coupler_8_to_16.sv
// Packs pairs of 8-record words from an FWFT FIFO into 16-record words, preserving the
// all-zero-low-record terminator. Optional key-order checker: define COUPLER_ORDER_CHECK_EN.
module coupler_8_to_16 #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned KEY_WIDTH  = 80
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [8*DATA_WIDTH-1:0]   i_fifo,
  input  logic                      i_fifo_empty,
  output logic                      o_fifo_read,
  input  logic                      i_fifo_out_ready,
  output logic                      o_out_fifo_write,
  output logic [16*DATA_WIDTH-1:0]  o_data
`ifdef COUPLER_ORDER_CHECK_EN
  ,
  output logic                      o_order_err
`endif
);

  if (KEY_WIDTH == 0 || KEY_WIDTH > DATA_WIDTH) begin : g_key_width_check
    $error("KEY_WIDTH must be in 1..DATA_WIDTH");
  end

  typedef enum logic [1:0] {S_EMPTY, S_HALF, S_TERM} state_e;

  state_e                    r_state;
  logic [8*DATA_WIDTH-1:0]   r_hold;
  logic                      r_out_valid;
  logic                      w_term;
  logic                      w_out_free;
  logic                      w_ready_in;

  assign w_term     = (i_fifo[DATA_WIDTH-1:0] == '0);
  assign w_out_free = ~r_out_valid | i_fifo_out_ready;

  // A lone terminator in S_EMPTY needs the output slot; a first half does not.
  always_comb begin
    w_ready_in = 1'b0;
    case (r_state)
      S_EMPTY: w_ready_in = ~w_term | w_out_free;
      S_HALF:  w_ready_in = w_out_free;
      default: w_ready_in = 1'b0;
    endcase
  end

  assign o_fifo_read      = i_rst_n & ~i_fifo_empty & w_ready_in;
  assign o_out_fifo_write = i_rst_n & r_out_valid & i_fifo_out_ready;

`ifdef COUPLER_ORDER_CHECK_EN
  logic r_order_err;
  assign o_order_err = r_order_err;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_EMPTY;
      r_hold      <= '0;
      r_out_valid <= 1'b0;
      o_data      <= '0;
`ifdef COUPLER_ORDER_CHECK_EN
      r_order_err <= 1'b0;
`endif
    end else begin
      // Drain first; a load below in the same cycle overrides the clear.
      if (o_out_fifo_write) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        S_EMPTY: begin
          if (o_fifo_read) begin
            if (!w_term) begin
              r_hold  <= i_fifo;
              r_state <= S_HALF;
            end else begin
              o_data      <= '0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_HALF: begin
          if (o_fifo_read) begin
            r_out_valid <= 1'b1;
            if (!w_term) begin
              o_data  <= {i_fifo, r_hold};
              r_state <= S_EMPTY;
`ifdef COUPLER_ORDER_CHECK_EN
              if (r_hold[7*DATA_WIDTH +: KEY_WIDTH] > i_fifo[KEY_WIDTH-1:0]) begin
                r_order_err <= 1'b1;
              end
`endif
            end else begin
              o_data  <= {{(8*DATA_WIDTH){1'b0}}, r_hold};
              r_state <= S_TERM;
            end
          end
        end
        S_TERM: begin
          if (w_out_free) begin
            o_data      <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_coupler_8_to_16.sv
// Self-checking bench for coupler_8_to_16: directed scenarios plus a randomized stream
// compared against a stream-level packing model.
module tb_coupler_8_to_16;

  localparam int unsigned DW = 16;
  localparam int unsigned KW = 12;

  typedef logic [8*DW-1:0]  word_t;
  typedef logic [16*DW-1:0] dword_t;

  logic   clk = 1'b0;
  logic   rst_n;
  word_t  fifo;
  logic   fifo_empty;
  logic   fifo_read;
  logic   out_ready;
  logic   out_write;
  dword_t data;
`ifdef COUPLER_ORDER_CHECK_EN
  logic   order_err;
`endif

  int checks = 0;
  int failures = 0;

  word_t  src_q[$];
  dword_t got_q[$];
  int     rd_cyc[$];
  int     wr_cyc[$];
  int     cyc = 0;
  int     n_reads = 0;
  int     gap_pct = 0;
  bit     rand_ready = 1'b0;
  logic   s_rd, s_wr;
  dword_t s_data;

  coupler_8_to_16 #(
    .DATA_WIDTH (DW),
    .KEY_WIDTH  (KW)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_fifo           (fifo),
    .i_fifo_empty     (fifo_empty),
    .o_fifo_read      (fifo_read),
    .i_fifo_out_ready (out_ready),
    .o_out_fifo_write (out_write),
    .o_data           (data)
`ifdef COUPLER_ORDER_CHECK_EN
    ,
    .o_order_err      (order_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < 4; i++) w[i*32 +: 32] = $urandom;
    if (w[DW-1:0] == '0) w[0] = 1'b1;
    return w;
  endfunction

  // Terminator with random upper records, which must be ignored.
  function automatic word_t term_word();
    word_t w;
    w = rand_word();
    w[DW-1:0] = '0;
    return w;
  endfunction

  // Stream-level reference: pair non-terminators, flush a half before each terminator.
  function automatic void model(input word_t in_q[$], output dword_t out_q[$]);
    bit    pend_v = 1'b0;
    word_t pend = '0;
    out_q.delete();
    foreach (in_q[i]) begin
      if (in_q[i][DW-1:0] == '0) begin
        if (pend_v) out_q.push_back({{(8*DW){1'b0}}, pend});
        out_q.push_back('0);
        pend_v = 1'b0;
      end else if (pend_v) begin
        out_q.push_back({in_q[i], pend});
        pend_v = 1'b0;
      end else begin
        pend   = in_q[i];
        pend_v = 1'b1;
      end
    end
  endfunction

  task automatic drive();
    if (src_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      fifo       = src_q[0];
      fifo_empty = 1'b0;
    end else begin
      fifo       = rand_word();
      fifo_empty = 1'b1;
    end
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    @(negedge clk);
    s_rd   = fifo_read;
    s_wr   = out_write;
    s_data = data;
    @(posedge clk);
    #1;
    if (s_rd) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      n_reads++;
      rd_cyc.push_back(cyc);
    end
    if (s_wr) begin
      got_q.push_back(s_data);
      wr_cyc.push_back(cyc);
    end
    cyc++;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_writes(input int n, input int budget);
    while (got_q.size() < n && budget > 0) begin
      tick();
      budget--;
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    rd_cyc.delete();
    wr_cyc.delete();
    n_reads = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_q.delete();
    run(2);
    rst_n = 1'b1;
    clear_logs();
  endtask

  function automatic dword_t got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : 'x;
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    src_q.delete();
    src_q.push_back(rand_word());
    drive();
    run(3);
    checks++;
    if (s_rd !== 1'b0) begin
      failures++;
      $display("FAIL reset_read: got %b want 0", s_rd);
    end
    checks++;
    if (s_wr !== 1'b0) begin
      failures++;
      $display("FAIL reset_write: got %b want 0", s_wr);
    end
    checks++;
    if (data !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h want 0", data);
    end
`ifdef COUPLER_ORDER_CHECK_EN
    checks++;
    if (order_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_order_err: got %b want 0", order_err);
    end
`endif
    src_q.delete();
    drive();
    rst_n = 1'b1;
    clear_logs();
    run(3);
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL reset_idle_writes: got %0d want 0", got_q.size());
    end
  endtask

  task automatic test_pairing();
    word_t w1, w2;
    clear_logs();
    w1 = rand_word();
    w2 = rand_word();
    w1[DW-1:0] = 1;
    w2[DW-1:0] = 2;
    out_ready = 1'b1;
    src_q = '{w1, w2};
    drive();
    wait_writes(1, 20);
    run(4);
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL pair_count: got %0d want 1", got_q.size());
    end
    checks++;
    if (got_at(0) !== {w2, w1}) begin
      failures++;
      $display("FAIL pair_data: got %h want %h", got_at(0), {w2, w1});
    end
    checks++;
    if ((wr_cyc.size() > 0 ? wr_cyc[0] : -1) != (rd_cyc.size() > 1 ? rd_cyc[1] + 1 : -2)) begin
      failures++;
      $display("FAIL pair_latency: write edge %0d want read edge+1 %0d",
               wr_cyc.size() > 0 ? wr_cyc[0] : -1, rd_cyc.size() > 1 ? rd_cyc[1] + 1 : -2);
    end
  endtask

  task automatic test_odd_length();
    word_t w5, a, b;
    clear_logs();
    w5 = rand_word();
    w5[DW-1:0] = 5;
    a = rand_word();
    b = rand_word();
    out_ready = 1'b1;
    src_q = '{w5, term_word(), a, b};
    drive();
    wait_writes(3, 30);
    run(4);
    checks++;
    if (got_q.size() != 3) begin
      failures++;
      $display("FAIL odd_count: got %0d want 3", got_q.size());
    end
    checks++;
    if (got_at(0) !== {{(8*DW){1'b0}}, w5}) begin
      failures++;
      $display("FAIL odd_half: got %h want %h", got_at(0), {{(8*DW){1'b0}}, w5});
    end
    checks++;
    if (got_at(1) !== '0) begin
      failures++;
      $display("FAIL odd_term: got %h want 0", got_at(1));
    end
    // A fresh pair afterwards proves the terminator left the block empty.
    checks++;
    if (got_at(2) !== {b, a}) begin
      failures++;
      $display("FAIL odd_next_pair: got %h want %h", got_at(2), {b, a});
    end
  endtask

  task automatic test_term_alone();
    clear_logs();
    out_ready = 1'b1;
    src_q = '{term_word()};
    drive();
    wait_writes(1, 20);
    run(4);
    checks++;
    if (got_q.size() != 1 || got_at(0) !== '0) begin
      failures++;
      $display("FAIL term_alone: got count %0d data %h want 1 x 0", got_q.size(), got_at(0));
    end
    checks++;
    if (n_reads != 1) begin
      failures++;
      $display("FAIL term_alone_reads: got %0d want 1", n_reads);
    end
  endtask

  task automatic test_backpressure();
    word_t  w[6];
    word_t  in_q[$];
    dword_t exp_q[$];
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w[i] = rand_word();
      in_q.push_back(w[i]);
    end
    src_q = in_q;
    model(in_q, exp_q);
    drive();
    run(4);
    checks++;
    if (data !== {w[1], w[0]}) begin
      failures++;
      $display("FAIL bp_data_early: got %h want %h", data, {w[1], w[0]});
    end
    run(10);
    checks++;
    if (data !== {w[1], w[0]}) begin
      failures++;
      $display("FAIL bp_data_stable: got %h want %h", data, {w[1], w[0]});
    end
    checks++;
    if (n_reads != 3) begin
      failures++;
      $display("FAIL bp_reads: got %0d want 3", n_reads);
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL bp_no_write: got %0d want 0", got_q.size());
    end
    out_ready = 1'b1;
    wait_writes(3, 40);
    run(4);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_drain_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_at(i) !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_drain_%0d: got %h want %h", i, got_at(i), exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    word_t a, b;
    clear_logs();
    out_ready = 1'b0;
    src_q = '{rand_word(), rand_word(), rand_word()};
    drive();
    run(8);
    checks++;
    if (n_reads != 3) begin
      failures++;
      $display("FAIL midrst_setup_reads: got %0d want 3", n_reads);
    end
    rst_n     = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (s_wr !== 1'b0) begin
      failures++;
      $display("FAIL midrst_write_in_reset: got %b want 0", s_wr);
    end
    rst_n = 1'b1;
    checks++;
    if (data !== '0) begin
      failures++;
      $display("FAIL midrst_data: got %h want 0", data);
    end
    clear_logs();
    run(4);
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL midrst_pending: got %0d writes want 0", got_q.size());
    end
    a = rand_word();
    b = rand_word();
    src_q = '{a, b};
    drive();
    wait_writes(1, 20);
    run(4);
    checks++;
    if (got_q.size() != 1 || got_at(0) !== {b, a}) begin
      failures++;
      $display("FAIL midrst_repack: got count %0d data %h want 1 x %h",
               got_q.size(), got_at(0), {b, a});
    end
  endtask

  task automatic test_random_stream();
    word_t  in_q[$];
    dword_t exp_q[$];
    int     budget = 4000;
    clear_logs();
    for (int i = 0; i < 80; i++) begin
      in_q.push_back(($urandom_range(0, 99) < 20) ? term_word() : rand_word());
    end
    in_q.push_back(term_word());
    model(in_q, exp_q);
    src_q      = in_q;
    gap_pct    = 30;
    rand_ready = 1'b1;
    drive();
    while ((src_q.size() > 0 || got_q.size() < exp_q.size()) && budget > 0) begin
      tick();
      budget--;
    end
    gap_pct    = 0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    run(5);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_at(i) !== exp_q[i]) begin
        failures++;
        $display("FAIL rand_word_%0d: got %h want %h", i, got_at(i), exp_q[i]);
      end
    end
  endtask

`ifdef COUPLER_ORDER_CHECK_EN
  task automatic test_order_check();
    word_t hi, lo;
    do_reset();
    out_ready = 1'b1;
    hi = rand_word();
    lo = rand_word();
    hi[7*DW +: KW] = 9;
    lo[KW-1:0] = 3;
    src_q = '{hi, lo};
    drive();
    run(6);
    checks++;
    if (order_err !== 1'b1) begin
      failures++;
      $display("FAIL order_set: got %b want 1", order_err);
    end
    hi[7*DW +: KW] = 1;
    lo[KW-1:0] = 2;
    src_q = '{hi, lo};
    drive();
    run(6);
    checks++;
    if (order_err !== 1'b1) begin
      failures++;
      $display("FAIL order_sticky: got %b want 1", order_err);
    end
    do_reset();
    hi[7*DW +: KW] = 3;
    lo[KW-1:0] = 9;
    src_q = '{hi, lo};
    hi[7*DW +: KW] = 4;
    lo[KW-1:0] = 4;
    src_q.push_back(hi);
    src_q.push_back(lo);
    drive();
    run(8);
    checks++;
    if (order_err !== 1'b0) begin
      failures++;
      $display("FAIL order_clean: got %b want 0", order_err);
    end
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    out_ready  = 1'b0;
    fifo       = '0;
    fifo_empty = 1'b1;
    test_reset();
    test_pairing();
    test_odd_length();
    test_term_alone();
    test_backpressure();
    test_reset_mid();
    test_random_stream();
`ifdef COUPLER_ORDER_CHECK_EN
    test_order_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
